// File: rtl/k_vote_pkg.sv
// Shared definitions for the KNN class-vote stage: FSM states, vote modes
// and the score-width helper.
package k_vote_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam logic VOTE_MAJORITY = 1'b0;
  localparam logic VOTE_RANK     = 1'b1;

  // Bits needed to hold the largest rank-weighted sum K + (K-1) + ... + 1.
  function automatic int score_w(input int k);
    return $clog2(k * (k + 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/k_vote_tally.sv
// Per-class score and first-occurrence-rank registers.  Accumulates one
// weighted beat per cycle, clears every class in one cycle, and offers a
// combinational read port for the class scan.
module k_vote_tally
  import k_vote_pkg::*;
#(
  parameter int TYPE_W  = 2,
  parameter int SCORE_W = 4,
  parameter int RANK_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               upd_en,
  input  logic [TYPE_W-1:0]  upd_type,
  input  logic [SCORE_W-1:0] upd_weight,
  input  logic [RANK_W-1:0]  upd_rank,
  input  logic [TYPE_W-1:0]  rd_idx,
  output logic [SCORE_W-1:0] rd_score,
  output logic [RANK_W-1:0]  rd_first_rank
);

  localparam int C = 1 << TYPE_W;

  logic [SCORE_W-1:0] score_q      [C];
  logic [SCORE_W-1:0] score_d      [C];
  logic [RANK_W-1:0]  first_rank_q [C];
  logic [RANK_W-1:0]  first_rank_d [C];

  // Next tallies: clear wins over update; a zero score marks a class not yet
  // seen in this vector, since every accepted beat adds at least 1.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      score_d[i]      = score_q[i];
      first_rank_d[i] = first_rank_q[i];
      if (clr) begin
        score_d[i]      = '0;
        first_rank_d[i] = '0;
      end else if (upd_en && (upd_type == TYPE_W'(i))) begin
        score_d[i] = score_q[i] + upd_weight;
        if (score_q[i] == '0) begin
          first_rank_d[i] = upd_rank;
        end
      end
    end
  end

  // Tally registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < C; i++) begin
      if (rst) begin
        score_q[i]      <= '0;
        first_rank_q[i] <= '0;
      end else begin
        score_q[i]      <= score_d[i];
        first_rank_q[i] <= first_rank_d[i];
      end
    end
  end

  assign rd_score      = score_q[rd_idx];
  assign rd_first_rank = first_rank_q[rd_idx];

endmodule

// File: rtl/k_vote.sv
// Streaming KNN class vote: accumulates up to K ranked labels, scans every
// class for the highest score (ties go to the class seen nearest) and
// presents the winner through a valid/ready handshake.
module k_vote
  import k_vote_pkg::*;
#(
  parameter int K       = 5,
  parameter int TYPE_W  = 2,
  parameter int SCORE_W = score_w(K),
  parameter int RANK_W  = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TYPE_W-1:0]  in_type,
  input  logic               in_last,
  input  logic               weighted,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TYPE_W-1:0]  out_type,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_tie
);

  state_t             state_q, state_d;
  logic [RANK_W-1:0]  rank_q, rank_d;
  logic               mode_q, mode_d;
  logic [TYPE_W-1:0]  j_q, j_d;
  logic [TYPE_W-1:0]  best_type_q, best_type_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [RANK_W-1:0]  best_rank_q, best_rank_d;
  logic               tie_q, tie_d;
  logic [TYPE_W-1:0]  out_type_q, out_type_d;
  logic [SCORE_W-1:0] out_score_q, out_score_d;
  logic               out_tie_q, out_tie_d;

  logic               tally_clr;
  logic               tally_upd;
  logic [SCORE_W-1:0] beat_weight;
  logic               eff_mode;
  logic [SCORE_W-1:0] rd_score;
  logic [RANK_W-1:0]  rd_first_rank;

  k_vote_tally #(
    .TYPE_W (TYPE_W),
    .SCORE_W(SCORE_W),
    .RANK_W (RANK_W)
  ) u_tally (
    .clk          (clk),
    .rst          (rst),
    .clr          (tally_clr),
    .upd_en       (tally_upd),
    .upd_type     (in_type),
    .upd_weight   (beat_weight),
    .upd_rank     (rank_q),
    .rd_idx       (j_q),
    .rd_score     (rd_score),
    .rd_first_rank(rd_first_rank)
  );

  // The first beat of a vector uses the live mode input; later beats use
  // the value latched on that first beat.
  assign eff_mode    = (rank_q == '0) ? weighted : mode_q;
  assign beat_weight = (eff_mode == VOTE_RANK) ? (SCORE_W'(K) - SCORE_W'(rank_q))
                                               : SCORE_W'(1);

  // Next-state, scan comparison and handshake control.
  always_comb begin
    state_d      = state_q;
    rank_d       = rank_q;
    mode_d       = mode_q;
    j_d          = j_q;
    best_type_d  = best_type_q;
    best_score_d = best_score_q;
    best_rank_d  = best_rank_q;
    tie_d        = tie_q;
    out_type_d   = out_type_q;
    out_score_d  = out_score_q;
    out_tie_d    = out_tie_q;
    tally_clr    = 1'b0;
    tally_upd    = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          tally_upd = 1'b1;
          rank_d    = rank_q + 1'b1;
          if (rank_q == '0) begin
            mode_d = weighted;
          end
          // A last flag on the K-th beat ends the vector just once.
          if (in_last || (rank_q == RANK_W'(K - 1))) begin
            state_d      = ST_SCAN;
            j_d          = '0;
            best_type_d  = '0;
            best_score_d = '0;
            best_rank_d  = '1;
            tie_d        = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        if (rd_score != '0) begin
          if (rd_score > best_score_q) begin
            best_type_d  = j_q;
            best_score_d = rd_score;
            best_rank_d  = rd_first_rank;
            tie_d        = 1'b0;
          end else if (rd_score == best_score_q) begin
            tie_d = 1'b1;
            if (rd_first_rank < best_rank_q) begin
              best_type_d = j_q;
              best_rank_d = rd_first_rank;
            end
          end
        end
        j_d = j_q + 1'b1;
        if (&j_q) begin
          state_d     = ST_OUT;
          out_type_d  = best_type_d;
          out_score_d = best_score_d;
          out_tie_d   = tie_d;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          tally_clr = 1'b1;
          rank_d    = '0;
          j_d       = '0;
          state_d   = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      rank_q       <= '0;
      mode_q       <= VOTE_MAJORITY;
      j_q          <= '0;
      best_type_q  <= '0;
      best_score_q <= '0;
      best_rank_q  <= '1;
      tie_q        <= 1'b0;
      out_type_q   <= '0;
      out_score_q  <= '0;
      out_tie_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      mode_q       <= mode_d;
      j_q          <= j_d;
      best_type_q  <= best_type_d;
      best_score_q <= best_score_d;
      best_rank_q  <= best_rank_d;
      tie_q        <= tie_d;
      out_type_q   <= out_type_d;
      out_score_q  <= out_score_d;
      out_tie_q    <= out_tie_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign out_type  = out_type_q;
  assign out_score = out_score_q;
  assign out_tie   = out_tie_q;

endmodule

// File: doc/k_vote.md
# k_vote

Streaming class-vote stage of the KNN pipeline. It accepts the K sorted nearest-neighbour labels one per cycle, nearest first, through a valid/ready handshake. It tallies them by plain majority or by rank-weighted vote and scans all classes. It returns the winning label, its score and a tie flag through a second valid/ready handshake. Ties are resolved deterministically in favour of the class that appears nearest.

## Interface
Parameters:
- K, 5: neighbours per query; at most K beats per vector, K ≥ 1.
- TYPE_W, 2: label width; C = 2^TYPE_W classes.
- SCORE_W, $clog2(K*(K+1)/2+1): score width; holds the maximum weighted sum.
- RANK_W, $clog2(K+1): rank counter width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: neighbour beat valid.
- in_ready, output, 1: block accepts beats.
- in_type, input, TYPE_W: neighbour label.
- in_last, input, 1: final beat of the vector.
- weighted, input, 1: vote mode, sampled on the first beat of a vector.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_type, output, TYPE_W: winning label.
- out_score, output, SCORE_W: winning score.
- out_tie, output, 1: another class reached the winning score.

## Operation
- States: ACCUM, SCAN, OUT. Reset enters ACCUM.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - rank counts accepted beats from 0.
  - Beat weight: 1 when the latched mode is 0; K−rank when it is 1 (nearest beat weighs K).
  - score[in_type] += weight.
  - On the first occurrence of a class in the vector, first_rank[in_type] <= rank.
  - The mode is latched on the beat with rank=0.
- End of vector: the accepted beat with in_last=1, or the K-th beat, whichever comes first. A beat with in_last=1 at rank K−1 counts once. The next state is SCAN.
- SCAN: one class per cycle, j = 0..C−1. Class j replaces the best when:
  - score[j] ≠ 0, and
  - score[j] > best_score, or score[j] == best_score with first_rank[j] < best_rank.
- Tie tracking during SCAN:
  - Set tie when score[j] ≠ 0 and score[j] == best_score.
  - Clear tie when a strictly greater score is found.
  - best_score, best_rank and tie clear on entry to SCAN.
- SCAN exits to OUT after j = C−1.
- OUT:
  - out_valid=1. out_type, out_score and out_tie hold stable until out_ready=1.
  - On the handshake, all score, first_rank, rank and j registers clear in one cycle. The next state is ACCUM.
- Zero-score classes never win. At least one beat always precedes SCAN, so a winner always exists.
- No arithmetic overflow: SCORE_W covers K(K+1)/2.

## Timing
- Reset values: in_ready=1 (in ACCUM), out_valid=0, out_type=0, out_score=0, out_tie=0. All tallies are cleared.
- Reset mid-vector discards partial tallies. The next vector starts clean.
- Throughput: one beat per cycle in ACCUM.
- Latency: last beat accepted in cycle t → SCAN in cycles t+1..t+C → out_valid=1 in cycle t+C+1.
- Back-to-back: the next vector's first beat can be accepted in the cycle after the out handshake. Minimum period is L+C+1 cycles for L beats.
- in_ready=0 in SCAN and OUT. in_valid is ignored there, and no beat is lost or double-counted.
- out_valid deasserts the cycle after the handshake. Outputs keep their last value until the next result.

## Structure
- Shared knn package holds:
  - the state enum (ACCUM/SCAN/OUT);
  - the vote-mode constants (VOTE_MAJORITY=0, VOTE_RANK=1);
  - a function computing SCORE_W from K.
- One sub-module is natural: k_vote_tally. It owns the score and first_rank register arrays, provides the per-beat update and single-cycle clear ports, and exposes a read port indexed by j.
- SCAN, OUT and the handshakes stay in k_vote.

## Test plan
All scenarios use K=5, TYPE_W=2.
- Majority mode, labels 1,2,1,3,1 with in_last on beat 5 → out_type=1, out_score=3, out_tie=0; out_valid rises 5 cycles after the last beat.
- Majority mode, labels 2,3,3,2,0 → out_type=2 (first_rank 0 beats 1), out_score=2, out_tie=1.
- Rank-weighted mode, labels 0,0,1,1,1 → out_type=0, out_score=9, out_tie=0. The same vector in majority mode gives out_type=1, out_score=3.
- Early last: in_last on beat 2, labels 3,1, majority mode → out_type=3, out_score=1, out_tie=1.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid stays 1, outputs stable, in_ready=0. Drive in_valid=1 throughout; those beats must be ignored. After the handshake, vector 0,0,0,0,0 → out_type=0, out_score=5 (no carry-over).
- Assert rst after 3 beats of labels 2,2,2 → outputs return to reset values. The following vector 1,1,0,0,1 in majority mode → out_type=1, out_score=3.
